fpu_wb_cmd_regs: RTL and testbench

// Wishbone-classic slave register bank and command sequencer between the user-project Wishbone port and the FPU core.

---
 rtl/fpu_wb_cmd_regs.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fpu_wb_cmd_regs.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_cmd_regs.sv
// Wishbone-classic register bank and command sequencer in front of the FPU core.
// Holds operands, rounding mode and operation; issues a one-cycle start strobe,
// then waits for the FPU result or a timeout and reports done/timeout status.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no command in flight; waits for a start write to OP
// ISSUE | fpu_valid_o high for this single cycle
// WAIT  | waiting for fpu_valid_i; timeout down-counter running
//
// Register writes commit on the clock edge that ends the ack cycle, so the
// master must hold stb/cyc/adr/dat through ack (standard classic handshake).
// That commit point plus the IDLE->ISSUE hop gives the 2-cycle ack-to-strobe
// latency.
module fpu_wb_cmd_regs #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned OP_W     = 12,
    parameter logic [15:0] TIMEOUT  = 16'd1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [31:0]     fpu_a_o,
    output logic [31:0]     fpu_b_o,
    output logic [31:0]     fpu_c_o,
    output logic [OP_W-1:0] fpu_op_o,
    output logic [2:0]      fpu_rm_o,
    output logic            fpu_valid_o,
    input  logic [31:0]     fpu_result_i,
    input  logic [4:0]      fpu_flags_i,
    input  logic            fpu_valid_i,
    output logic            irq_o
);

    localparam logic [7:0] OFF_A      = 8'h00;
    localparam logic [7:0] OFF_B      = 8'h04;
    localparam logic [7:0] OFF_C      = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_FLAGS  = 8'h10;
    localparam logic [7:0] OFF_STATUS = 8'h14;
    localparam logic [7:0] OFF_OP     = 8'h1C;
    localparam logic [7:0] OFF_RM     = 8'h24;

    // byte lane that carries the OP valid bit
    localparam int unsigned VALID_LANE = OP_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]     a_q, b_q, c_q, result_q;
    logic [4:0]      flags_q;
    logic [OP_W-1:0] op_q, op_d;
    logic [2:0]      rm_q;
    logic            ie_q, done_q, timeout_q, wr_busy_q, start_pend_q;
    logic [15:0]     cnt_q;
    logic            ack_q;
    logic [31:0]     dat_q, rd_data;

    logic            adr_hit, req, wr_en, busy;
    logic [7:0]      off;
    logic            wr_status, wr_data_reg, wr_start;
    logic            go_issue, load_cnt, dec_cnt, set_done, set_timeout;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    assign off     = wbs_adr_i[7:0];
    assign adr_hit = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign req     = wbs_stb_i & wbs_cyc_i & adr_hit;
    // commit point: the ack cycle of a write
    assign wr_en   = ack_q & req & wbs_we_i;

    // a pending start counts as busy so nothing slips in before ISSUE
    assign busy    = (state_q != ST_IDLE) | start_pend_q;

    assign wr_status   = wr_en & (off == OFF_STATUS);
    assign wr_data_reg = wr_en & ((off == OFF_A) | (off == OFF_B) | (off == OFF_C) |
                                  (off == OFF_OP) | (off == OFF_RM));
    assign wr_start    = wr_en & (off == OFF_OP) & ~busy &
                         wbs_sel_i[VALID_LANE] & wbs_dat_i[OP_W];

    // per-bit byte-masked merge of the op field
    always_comb begin
        op_d = op_q;
        for (int i = 0; i < int'(OP_W); i++) begin
            if (wbs_sel_i[i/8]) begin
                op_d[i] = wbs_dat_i[i];
            end
        end
    end

    // read mux; unmapped offsets return zero
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_A:      rd_data = a_q;
            OFF_B:      rd_data = b_q;
            OFF_C:      rd_data = c_q;
            OFF_RESULT: rd_data = result_q;
            OFF_FLAGS:  rd_data = {27'b0, flags_q};
            OFF_STATUS: rd_data = {23'b0, ie_q, 4'b0, wr_busy_q, timeout_q, done_q, busy};
            OFF_OP:     rd_data[OP_W-1:0] = op_q;
            OFF_RM:     rd_data = {29'b0, rm_q};
            default:    rd_data = '0;
        endcase
    end

    // one-wait-state ack and read data, both single-cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req & ~ack_q;
            dat_q <= (req & ~ack_q) ? rd_data : 32'h0;
        end
    end

    // operand/config registers; dropped while a command is in flight
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            op_q <= '0;
            rm_q <= '0;
        end else if (wr_en && !busy) begin
            case (off)
                OFF_A:   a_q  <= byte_merge(a_q, wbs_dat_i, wbs_sel_i);
                OFF_B:   b_q  <= byte_merge(b_q, wbs_dat_i, wbs_sel_i);
                OFF_C:   c_q  <= byte_merge(c_q, wbs_dat_i, wbs_sel_i);
                OFF_OP:  op_q <= op_d;
                OFF_RM:  if (wbs_sel_i[0]) rm_q <= wbs_dat_i[2:0];
                default: ;
            endcase
        end
    end

    // interrupt enable, writable at any time
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ie_q <= 1'b0;
        end else if (wr_status && wbs_sel_i[1]) begin
            ie_q <= wbs_dat_i[8];
        end
    end

    // start request latched by the OP write, consumed by IDLE->ISSUE
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            start_pend_q <= 1'b0;
        end else if (go_issue) begin
            start_pend_q <= 1'b0;
        end else if (wr_start) begin
            start_pend_q <= 1'b1;
        end
    end

    // sticky status bits; hardware set beats a same-cycle W1C
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_busy_q <= 1'b0;
        end else begin
            if (set_done) begin
                done_q <= 1'b1;
            end else if (go_issue || (wr_status && wbs_sel_i[0] && wbs_dat_i[1])) begin
                done_q <= 1'b0;
            end

            if (set_timeout) begin
                timeout_q <= 1'b1;
            end else if (go_issue || (wr_status && wbs_sel_i[0] && wbs_dat_i[2])) begin
                timeout_q <= 1'b0;
            end

            if (wr_data_reg && busy) begin
                wr_busy_q <= 1'b1;
            end else if (wr_status && wbs_sel_i[0] && wbs_dat_i[3]) begin
                wr_busy_q <= 1'b0;
            end
        end
    end

    // result capture only on a response accepted in WAIT
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (set_done) begin
            result_q <= fpu_result_i;
            flags_q  <= fpu_flags_i;
        end
    end

    // timeout down-counter, terminal count at zero
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (load_cnt) begin
            cnt_q <= TIMEOUT;
        end else if (dec_cnt) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    // state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and sequencer strobes
    always_comb begin
        state_d     = state_q;
        fpu_valid_o = 1'b0;
        go_issue    = 1'b0;
        load_cnt    = 1'b0;
        dec_cnt     = 1'b0;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pend_q) begin
                    go_issue = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_valid_o = 1'b1;
                load_cnt    = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_valid_i) begin
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign fpu_a_o   = a_q;
    assign fpu_b_o   = b_q;
    assign fpu_c_o   = c_q;
    assign fpu_op_o  = op_q;
    assign fpu_rm_o  = rm_q;
    assign irq_o     = done_q & ie_q;

endmodule

// File: tb/tb_fpu_wb_cmd_regs.sv
// Directed bench for fpu_wb_cmd_regs: register access, start/issue timing,
// result capture, busy write drop, timeout and same-cycle precedence.
module tb_fpu_wb_cmd_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TMO  = 1024;

    localparam logic [31:0] A_ADR  = BASE + 32'h00;
    localparam logic [31:0] B_ADR  = BASE + 32'h04;
    localparam logic [31:0] RES_AD = BASE + 32'h0C;
    localparam logic [31:0] FLG_AD = BASE + 32'h10;
    localparam logic [31:0] ST_ADR = BASE + 32'h14;
    localparam logic [31:0] OP_ADR = BASE + 32'h1C;
    localparam logic [31:0] RM_ADR = BASE + 32'h24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat_o;
    logic [31:0] fa, fb, fc;
    logic [11:0] fop;
    logic [2:0]  frm;
    logic        fvalid_o;
    logic [31:0] fres = '0;
    logic [4:0]  fflags = '0;
    logic        fvalid_i = 1'b0;
    logic        irq;

    int vectors = 0;
    int errors  = 0;
    int cyc_cnt = 0;
    int ack_cyc = 0;

    fpu_wb_cmd_regs dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat_o),
        .fpu_a_o      (fa),
        .fpu_b_o      (fb),
        .fpu_c_o      (fc),
        .fpu_op_o     (fop),
        .fpu_rm_o     (frm),
        .fpu_valid_o  (fvalid_o),
        .fpu_result_i (fres),
        .fpu_flags_i  (fflags),
        .fpu_valid_i  (fvalid_i),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd, output logic acked);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                acked = 1'b1;
                rd = rdat_o;
                ack_cyc = cyc_cnt;
            end
        end
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic acked);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, s, dummy, acked);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd, output logic acked);
        wb_access(1'b0, a, 32'h0, 4'hF, rd, acked);
    endtask

    // waits (bounded) for the start strobe; returns at the negedge inside ISSUE
    task automatic wait_strobe(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (fvalid_o === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic fpu_respond(input logic [31:0] r, input logic [4:0] f);
        @(posedge clk); #1;
        fres = r; fflags = f; fvalid_i = 1'b1;
        @(posedge clk); #1;
        fvalid_i = 1'b0; fres = 32'hFFFF_FFFF; fflags = 5'h1F;
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic ak;
        @(negedge clk);
        vectors++;
        if ({ack, rdat_o, fa, fb, fc, fop, frm, fvalid_o, irq} !== '0) begin
            errors++; $display("FAIL reset_outputs: got ack=%b dat=%h a=%h op=%h valid=%b irq=%b exp all 0",
                               ack, rdat_o, fa, fop, fvalid_o, irq);
        end
        @(posedge clk); #1; rst = 1'b0;
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h0 || ak !== 1'b1) begin
            errors++; $display("FAIL reset_status: got %h ack=%b exp 00000000 ack=1", rd, ak);
        end
    endtask

    task automatic test_byte_sel;
        logic [31:0] rd; logic ak;
        wb_write(A_ADR, 32'h0, 4'hF, ak);
        wb_write(A_ADR, 32'h1234_5678, 4'b0011, ak);
        wb_read(A_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h0000_5678) begin
            errors++; $display("FAIL a_bytesel: got %h exp 00005678", rd);
        end
        wb_write(RM_ADR, 32'hFFFF_FFF6, 4'hF, ak);
        wb_read(RM_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h6) begin
            errors++; $display("FAIL rm_width: got %h exp 00000006", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] pat;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_ADR; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[5-i] = ack;
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        vectors++;
        if (pat !== 6'b010101) begin
            errors++; $display("FAIL back_to_back_ack: got %b exp 010101", pat);
        end
    endtask

    task automatic test_f2i;
        logic [31:0] rd; logic ak, seen;
        int start_ack, pulse_cyc, npulse;
        wb_write(ST_ADR, 32'h100, 4'b0010, ak);
        wb_write(A_ADR, 32'h4049_0FDB, 4'hF, ak);
        wb_write(RM_ADR, 32'h1, 4'hF, ak);
        wb_write(OP_ADR, 32'h0000_1010, 4'b0011, ak);
        start_ack = ack_cyc;
        npulse = 0; pulse_cyc = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fvalid_o === 1'b1) begin
                if (npulse == 0) pulse_cyc = cyc_cnt;
                npulse++;
                vectors++;
                if (fa !== 32'h4049_0FDB || fop !== 12'h010 || frm !== 3'd1) begin
                    errors++; $display("FAIL issue_operands: got a=%h op=%h rm=%0d exp a=40490fdb op=010 rm=1",
                                       fa, fop, frm);
                end
            end
        end
        vectors++;
        if (pulse_cyc !== start_ack + 2 || npulse !== 1) begin
            errors++; $display("FAIL start_latency: got offset=%0d pulses=%0d exp offset=2 pulses=1",
                               pulse_cyc - start_ack, npulse);
        end
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h101 || irq !== 1'b0) begin
            errors++; $display("FAIL status_busy: got %h irq=%b exp 00000101 irq=0", rd, irq);
        end
        fpu_respond(32'h3, 5'h01);
        wb_read(RES_AD, rd, ak);
        vectors++;
        if (rd !== 32'h3) begin
            errors++; $display("FAIL f2i_result: got %h exp 00000003", rd);
        end
        wb_read(FLG_AD, rd, ak);
        vectors++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL f2i_flags: got %h exp 00000001", rd);
        end
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h102 || irq !== 1'b1) begin
            errors++; $display("FAIL f2i_done_irq: got %h irq=%b exp 00000102 irq=1", rd, irq);
        end
        wb_read(OP_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h010) begin
            errors++; $display("FAIL op_readback: got %h exp 00000010", rd);
        end
    endtask

    task automatic test_busy_write;
        logic [31:0] rd; logic ak, seen;
        int extra;
        wb_write(B_ADR, 32'h1111_1111, 4'hF, ak);
        wb_write(OP_ADR, 32'h0000_1010, 4'b0011, ak);
        wait_strobe(seen);
        vectors++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL busy_start: got no strobe exp strobe");
        end
        wb_write(B_ADR, 32'h5, 4'hF, ak);
        vectors++;
        if (ak !== 1'b1) begin
            errors++; $display("FAIL busy_ack: got ack=%b exp 1", ak);
        end
        wb_read(B_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h1111_1111 || fb !== 32'h1111_1111) begin
            errors++; $display("FAIL busy_drop_b: got %h exp 11111111", rd);
        end
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h109) begin
            errors++; $display("FAIL wr_busy_set: got %h exp 00000109", rd);
        end
        wb_write(OP_ADR, 32'h0000_1020, 4'b0011, ak);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fvalid_o === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0 || fop !== 12'h010) begin
            errors++; $display("FAIL busy_no_restart: got pulses=%0d op=%h exp pulses=0 op=010", extra, fop);
        end
        wb_write(ST_ADR, 32'h8, 4'b0001, ak);
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h101) begin
            errors++; $display("FAIL wr_busy_w1c: got %h exp 00000101", rd);
        end
        fpu_respond(32'h7, 5'h00);
        wb_write(ST_ADR, 32'h2, 4'b0001, ak);
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h100 || irq !== 1'b0) begin
            errors++; $display("FAIL done_w1c: got %h irq=%b exp 00000100 irq=0", rd, irq);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] rd; logic ak, seen;
        wb_write(OP_ADR, 32'h0000_1010, 4'b0011, ak);
        wait_strobe(seen);
        @(posedge clk);
        repeat (TMO - 1) @(posedge clk);
        #1;
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h101 || seen !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got %h strobe=%b exp 00000101 strobe=1", rd, seen);
        end
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h104 || irq !== 1'b0) begin
            errors++; $display("FAIL timeout_set: got %h irq=%b exp 00000104 irq=0", rd, irq);
        end
        wb_read(RES_AD, rd, ak);
        vectors++;
        if (rd !== 32'h7) begin
            errors++; $display("FAIL timeout_result_kept: got %h exp 00000007", rd);
        end
    endtask

    task automatic test_coincident;
        logic [31:0] rd; logic ak, seen;
        wb_write(OP_ADR, 32'h0000_1010, 4'b0011, ak);
        wait_strobe(seen);
        @(posedge clk);
        repeat (TMO) @(posedge clk);
        #1;
        fres = 32'hABCD_0123; fflags = 5'h10; fvalid_i = 1'b1;
        @(posedge clk); #1;
        fvalid_i = 1'b0; fres = 32'hFFFF_FFFF; fflags = 5'h1F;
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h102 || seen !== 1'b1) begin
            errors++; $display("FAIL last_count_result_wins: got %h exp 00000102", rd);
        end
        wb_read(RES_AD, rd, ak);
        vectors++;
        if (rd !== 32'hABCD_0123) begin
            errors++; $display("FAIL last_count_result: got %h exp abcd0123", rd);
        end
        wb_read(FLG_AD, rd, ak);
        vectors++;
        if (rd !== 32'h10) begin
            errors++; $display("FAIL last_count_flags: got %h exp 00000010", rd);
        end
    endtask

    task automatic test_idle_ignore;
        logic [31:0] rd; logic ak;
        fpu_respond(32'h5555_5555, 5'h02);
        wb_read(RES_AD, rd, ak);
        vectors++;
        if (rd !== 32'hABCD_0123) begin
            errors++; $display("FAIL idle_valid_ignored: got %h exp abcd0123", rd);
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] rd; logic ak, seen;
        wb_write(OP_ADR, 32'h0000_1010, 4'b0011, ak);
        wait_strobe(seen);
        @(posedge clk); #1;
        fork
            wb_write(ST_ADR, 32'h2, 4'b0001, ak);
            begin
                @(posedge clk); #1;
                fres = 32'h0000_0042; fflags = 5'h00; fvalid_i = 1'b1;
                @(posedge clk); #1;
                fvalid_i = 1'b0;
            end
        join
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h102 || irq !== 1'b1) begin
            errors++; $display("FAIL set_beats_w1c: got %h irq=%b exp 00000102 irq=1", rd, irq);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd; logic ak;
        wb_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, ak);
        wb_read(BASE + 32'h20, rd, ak);
        vectors++;
        if (rd !== 32'h0 || ak !== 1'b1) begin
            errors++; $display("FAIL unmapped_20: got %h ack=%b exp 00000000 ack=1", rd, ak);
        end
        wb_read(BASE + 32'h40, rd, ak);
        vectors++;
        if (rd !== 32'h0 || ak !== 1'b1) begin
            errors++; $display("FAIL unmapped_40: got %h ack=%b exp 00000000 ack=1", rd, ak);
        end
        wb_read(32'h3000_1000, rd, ak);
        vectors++;
        if (ak !== 1'b0) begin
            errors++; $display("FAIL outside_base_ack: got ack=%b exp 0", ak);
        end
        @(negedge clk);
        vectors++;
        if (rdat_o !== 32'h0) begin
            errors++; $display("FAIL idle_dat: got %h exp 00000000", rdat_o);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd; logic ak, seen;
        wb_write(OP_ADR, 32'h0000_1010, 4'b0011, ak);
        wait_strobe(seen);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({ack, rdat_o, fa, fb, fc, fop, frm, fvalid_o, irq} !== '0 || seen !== 1'b1) begin
            errors++; $display("FAIL reset_mid_wait: got a=%h b=%h op=%h rm=%0d irq=%b exp all 0",
                               fa, fb, fop, frm, irq);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wb_read(RES_AD, rd, ak);
        vectors++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h exp 00000000", rd);
        end
        wb_read(ST_ADR, rd, ak);
        vectors++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_status_idle: got %h exp 00000000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_byte_sel();
        test_back_to_back();
        test_f2i();
        test_busy_write();
        test_timeout();
        test_coincident();
        test_idle_ignore();
        test_same_cycle();
        test_unmapped();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
